// File: rtl/ild1420_tx_sched.sv
// ild1420_tx_sched: fixed-rate tick generator and round-robin frame scheduler for the ILD1420 UART serializer
module ild1420_tx_sched #(
    parameter int N_CH       = 4,
    parameter int TIMER_W    = 16,
    parameter int HS_TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [TIMER_W-1:0]   period,
    input  logic [N_CH-1:0]      req_valid,
    input  logic [16*N_CH-1:0]   req_distance,
    input  logic [2*N_CH-1:0]    req_error,
    output logic [N_CH-1:0]      req_ready,
    output logic                 tx_start,
    output logic [15:0]          tx_distance,
    output logic [1:0]           tx_error,
    input  logic                 tx_done,
    output logic [2:0]           active_ch,
    output logic [15:0]          frames_sent,
    output logic                 overrun,
    output logic                 hs_fault,
    input  logic                 flag_clr
);
    localparam int HW = $clog2(HS_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [HW-1:0]      hs_cnt_q, hs_cnt_d;
    logic [N_CH-1:0]    req_ready_q, req_ready_d;
    logic               tx_start_q, tx_start_d;
    logic [15:0]        tx_distance_q, tx_distance_d;
    logic [1:0]         tx_error_q, tx_error_d;
    logic [2:0]         active_ch_q, active_ch_d;
    logic [15:0]        frames_sent_q, frames_sent_d;
    logic               overrun_q, overrun_d;
    logic               hs_fault_q, hs_fault_d;
    logic               run, tick, found, ov_set, hs_set;
    logic [2:0]         grant, idx;
    logic [7:0]         valid_a;
    logic [15:0]        dist_a [8];
    logic [1:0]         err_a [8];

    // Unpack the flat request buses into 8-entry tables so a 3-bit channel index is always in range
    for (genvar g = 0; g < 8; g++) begin : g_unpack
        if (g < N_CH) begin : g_ch
            assign valid_a[g] = req_valid[g];
            assign dist_a[g]  = req_distance[16*g +: 16];
            assign err_a[g]   = req_error[2*g +: 2];
        end else begin : g_pad
            assign valid_a[g] = 1'b0;
            assign dist_a[g]  = '0;
            assign err_a[g]   = '0;
        end
    end

    // Frame-period timer: wraps to 0 on tick, held at 0 when stopped
    always_comb begin
        run     = enable && (period != '0);
        tick    = run && (timer_q >= period - TIMER_W'(1));
        timer_d = (run && !tick) ? timer_q + TIMER_W'(1) : '0;
    end

    // Round-robin search starting one past the last granted channel
    always_comb begin
        found = 1'b0;
        grant = active_ch_q;
        idx   = active_ch_q;
        for (int k = 1; k <= N_CH; k++) begin
            idx = 3'((int'(active_ch_q) + k) % N_CH);
            if (!found && valid_a[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    // Scheduler next state: issue frames on tick, track the done handshake, raise sticky flags
    always_comb begin
        state_d       = state_q;
        hs_cnt_d      = hs_cnt_q;
        tx_start_d    = 1'b0;
        req_ready_d   = '0;
        tx_distance_d = tx_distance_q;
        tx_error_d    = tx_error_q;
        active_ch_d   = active_ch_q;
        frames_sent_d = frames_sent_q;
        ov_set        = 1'b0;
        hs_set        = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick && tx_done) begin
                    tx_start_d    = 1'b1;
                    frames_sent_d = frames_sent_q + 16'd1;
                    hs_cnt_d      = '0;
                    state_d       = WAIT_BUSY;
                    tx_distance_d = found ? dist_a[grant] : tx_distance_q;
                    tx_error_d    = found ? err_a[grant] : 2'b11;
                    active_ch_d   = grant;
                    req_ready_d   = found ? N_CH'(8'b1 << grant) : '0;
                end
                ov_set = tick && !tx_done;
            end
            WAIT_BUSY: begin
                ov_set = tick;
                if (!tx_done) begin
                    state_d = WAIT_DONE;
                end else if (hs_cnt_q == HW'(HS_TIMEOUT - 1)) begin
                    hs_set  = 1'b1;
                    state_d = IDLE;
                end else begin
                    hs_cnt_d = hs_cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                ov_set  = tick;
                state_d = tx_done ? IDLE : WAIT_DONE;
            end
            default: state_d = IDLE;
        endcase
        overrun_d  = ov_set || (overrun_q && !flag_clr);
        hs_fault_d = hs_set || (hs_fault_q && !flag_clr);
    end

    // State and registered outputs; reset leaves active_ch at the last channel so channel 0 wins first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            hs_cnt_q      <= '0;
            req_ready_q   <= '0;
            tx_start_q    <= 1'b0;
            tx_distance_q <= '0;
            tx_error_q    <= '0;
            active_ch_q   <= 3'(N_CH - 1);
            frames_sent_q <= '0;
            overrun_q     <= 1'b0;
            hs_fault_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            hs_cnt_q      <= hs_cnt_d;
            req_ready_q   <= req_ready_d;
            tx_start_q    <= tx_start_d;
            tx_distance_q <= tx_distance_d;
            tx_error_q    <= tx_error_d;
            active_ch_q   <= active_ch_d;
            frames_sent_q <= frames_sent_d;
            overrun_q     <= overrun_d;
            hs_fault_q    <= hs_fault_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_start    = tx_start_q;
    assign tx_distance = tx_distance_q;
    assign tx_error    = tx_error_q;
    assign active_ch   = active_ch_q;
    assign frames_sent = frames_sent_q;
    assign overrun     = overrun_q;
    assign hs_fault    = hs_fault_q;
endmodule

// File: tb/tb_ild1420_tx_sched.sv
// tb_ild1420_tx_sched: directed checks of ild1420_tx_sched against a behavioural serializer
module tb_ild1420_tx_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] period = '0;
    logic [3:0]  req_valid = '0;
    logic [63:0] req_distance = '0;
    logic [7:0]  req_error = '0;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [15:0] tx_distance;
    logic [1:0]  tx_error;
    logic        tx_done = 1'b1;
    logic [2:0]  active_ch;
    logic [15:0] frames_sent;
    logic        overrun;
    logic        hs_fault;
    logic        flag_clr = 1'b0;

    int passed = 0;
    int total = 0;
    int ser_mode = 0;
    int ser_ph = 0;
    int lo_cnt = 0;
    int n;
    int cnt;

    ild1420_tx_sched #(.N_CH(4), .TIMER_W(16), .HS_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .period(period),
        .req_valid(req_valid), .req_distance(req_distance), .req_error(req_error),
        .req_ready(req_ready), .tx_start(tx_start), .tx_distance(tx_distance),
        .tx_error(tx_error), .tx_done(tx_done), .active_ch(active_ch),
        .frames_sent(frames_sent), .overrun(overrun), .hs_fault(hs_fault),
        .flag_clr(flag_clr)
    );

    always #5 clk = ~clk;

    // Serializer model: mode 0 drops done one cycle after start for 5 cycles, mode 1 for 20, mode 2 never
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            ser_ph = 0;
            lo_cnt = 0;
            tx_done = 1'b1;
        end else if (ser_ph == 0) begin
            if (tx_start && ser_mode != 2) ser_ph = 1;
        end else if (ser_ph == 1) begin
            tx_done = 1'b0;
            lo_cnt = (ser_mode == 1) ? 20 : 5;
            ser_ph = 2;
        end else begin
            lo_cnt--;
            if (lo_cnt == 0) begin
                tx_done = 1'b1;
                ser_ph = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_start(input int budget, output int m);
        m = 0;
        do begin
            @(posedge clk);
            #1;
            m++;
        end while (!tx_start && m < budget);
    endtask

    initial begin
        cyc(2);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_tx_distance", tx_distance, 0);
        chk("rst_tx_error", tx_error, 0);
        chk("rst_active_ch", active_ch, 3);
        chk("rst_frames", frames_sent, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_hs_fault", hs_fault, 0);

        rst = 1'b0;
        period = 16'd10;
        req_valid = 4'b0001;
        req_distance = 64'h0000_0000_0000_1234;
        enable = 1'b1;
        wait_start(15, n);
        chk("s1_gap0", n, 10);
        chk("s1_dist0", tx_distance, 16'h1234);
        chk("s1_err0", tx_error, 0);
        chk("s1_ready0", req_ready, 4'b0001);
        chk("s1_frames0", frames_sent, 1);
        chk("s1_ch0", active_ch, 0);
        cyc(1);
        chk("s1_start_pulse", tx_start, 0);
        chk("s1_ready_pulse", req_ready, 0);
        wait_start(15, n);
        chk("s1_gap1", n, 9);
        chk("s1_ready1", req_ready, 4'b0001);
        chk("s1_frames1", frames_sent, 2);

        req_valid = 4'b0000;
        wait_start(15, n);
        chk("s3_gap", n, 10);
        chk("s3_dist", tx_distance, 16'h1234);
        chk("s3_err", tx_error, 2'b11);
        chk("s3_ready", req_ready, 0);
        chk("s3_frames", frames_sent, 3);
        chk("s3_ch", active_ch, 0);

        cyc(3);
        rst = 1'b1;
        #1;
        chk("s6_rst_dist", tx_distance, 0);
        chk("s6_rst_err", tx_error, 0);
        chk("s6_rst_ch", active_ch, 3);
        chk("s6_rst_frames", frames_sent, 0);
        req_valid = 4'b1111;
        req_distance = 64'h0400_0300_0200_0100;
        cyc(1);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_start(15, n);
            chk("s2_gap", n, 10);
            chk("s2_ch", active_ch, k % 4);
            chk("s2_dist", tx_distance, ((k % 4) + 1) << 8);
            chk("s2_ready", req_ready, 1 << (k % 4));
            chk("s2_frames", frames_sent, k + 1);
        end

        ser_mode = 1;
        period = 16'd4;
        cnt = 0;
        for (int i = 1; i <= 23; i++) begin
            cyc(1);
            if (tx_start) cnt++;
            if (i == 3) chk("s4_ovr_before", overrun, 0);
            if (i == 4) chk("s4_ovr_set", overrun, 1);
        end
        chk("s4_busy_starts", cnt, 0);
        cyc(1);
        chk("s4_resume_start", tx_start, 1);
        chk("s4_resume_frames", frames_sent, 6);
        chk("s4_resume_ch", active_ch, 1);
        flag_clr = 1'b1;
        cyc(1);
        flag_clr = 1'b0;
        chk("s4_ovr_clr", overrun, 0);
        chk("s4_no_fault", hs_fault, 0);

        cyc(1);
        ser_mode = 2;
        wait_start(30, n);
        chk("s5_gap", n, 22);
        chk("s5_frames", frames_sent, 7);
        cyc(3);
        chk("s5_fault_before", hs_fault, 0);
        cyc(1);
        chk("s5_fault_set", hs_fault, 1);
        wait_start(10, n);
        chk("s5_restart_gap", n, 4);
        chk("s5_restart_frames", frames_sent, 8);
        flag_clr = 1'b1;
        cyc(1);
        chk("s5_clr_ovr", overrun, 0);
        chk("s5_clr_fault", hs_fault, 0);
        cyc(3);
        chk("s5_setwins_fault", hs_fault, 1);
        chk("s5_setwins_ovr", overrun, 1);
        cyc(1);
        flag_clr = 1'b0;
        chk("s5_clr2_fault", hs_fault, 0);
        chk("s5_clr2_ovr", overrun, 0);

        ser_mode = 0;
        wait_start(10, n);
        chk("s6_en_gap", n, 3);
        chk("s6_en_ch", active_ch, 0);
        enable = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (tx_start) cnt++;
        end
        chk("s6_en_starts", cnt, 0);
        chk("s6_en_frames", frames_sent, 9);
        chk("s6_en_fault", hs_fault, 0);
        chk("s6_en_ovr", overrun, 0);

        enable = 1'b1;
        period = 16'd0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (tx_start) cnt++;
        end
        chk("p0_starts", cnt, 0);

        period = 16'd20;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (tx_start) cnt++;
        end
        chk("plow_early", cnt, 0);
        period = 16'd5;
        wait_start(5, n);
        chk("plow_gap", n, 1);
        chk("plow_ch", active_ch, 1);
        chk("plow_dist", tx_distance, 16'h0200);
        chk("plow_frames", frames_sent, 10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
